ram_sdp_be: RTL and testbench

Parametrised simple-dual-port RAM: one write port, one read port, one clock. Successor to the fixed 32x8 single-port RAM. Adds byte-write enables, selectable read latency and read-during-write mode, out-of-range detection, and a post-reset clear engine. Serves as the generic on-chip storage primitive for the memory blocks in this design.

---
 rtl/ram_pkg.sv | 25 ++
 rtl/ram_clear_fsm.sv | 51 +++++
 rtl/ram_sdp_be.sv | 147 ++++++++++++++
 tb/tb_ram_sdp_be.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port byte-enable RAM.
package ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  // One byte lane of a byte-enable write: take the new byte when enabled.
  function automatic logic [BYTE_W-1:0] be_merge(
    input logic [BYTE_W-1:0] old_b,
    input logic [BYTE_W-1:0] new_b,
    input logic              be
  );
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Post-reset clear engine: walks every word once, writing zero, then reports ready.
import ram_pkg::*;

module ram_clear_fsm #(
  parameter int DEPTH          = 8,
  parameter int ADDR_W         = 3,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output ram_state_e        state,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_we = 1'b1;
      if (clr_cnt_q == LAST_ADDR) begin
        state_d   = ST_READY;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign state    = state_q;
  assign busy     = (state_q == ST_CLEAR);
  assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write behaviour, range checking and post-reset clear.
import ram_pkg::*;

module ram_sdp_be #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int BE_W          = WIDTH / 8,
  localparam int ADDR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [BE_W-1:0]   wbe,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam rdw_mode_e       RDW     = (RDW_MODE != 0) ? RDW_NEW : RDW_OLD;

  logic [WIDTH-1:0] mem_q [DEPTH];

  ram_state_e        state;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_clear_fsm #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic              ready, wr_in_range, rd_in_range, wr_ok, wr_fault, collide;
  logic [ADDR_W-1:0] waddr_idx, raddr_idx, mem_wr_addr;
  logic [WIDTH-1:0]  old_word, wr_merged, mem_wr_data, rd_now_data;
  logic              mem_wr_en, rd_now_valid, rd_now_err;

  always_comb begin
    ready       = (state == ST_READY);
    wr_in_range = ({1'b0, waddr} < DEPTH_C);
    rd_in_range = ({1'b0, raddr} < DEPTH_C);
    // Out-of-range addresses are steered to word 0 so the array is never indexed past its end.
    waddr_idx   = wr_in_range ? waddr : '0;
    raddr_idx   = rd_in_range ? raddr : '0;
    wr_ok       = ready && we && wr_in_range;
    wr_fault    = ready && we && !wr_in_range;

    old_word  = mem_q[waddr_idx];
    wr_merged = old_word;
    for (int b = 0; b < BE_W; b++) begin
      wr_merged[b*BYTE_W +: BYTE_W] = be_merge(old_word[b*BYTE_W +: BYTE_W],
                                               wdata[b*BYTE_W +: BYTE_W], wbe[b]);
    end

    collide      = wr_ok && rd_in_range && (waddr == raddr);
    rd_now_valid = ready && re;
    rd_now_err   = rd_now_valid && !rd_in_range;
    if (!rd_in_range) begin
      rd_now_data = '0;
    end else if (collide && (RDW == RDW_NEW)) begin
      rd_now_data = wr_merged;
    end else begin
      rd_now_data = mem_q[raddr_idx];
    end

    mem_wr_en   = clr_we || wr_ok;
    mem_wr_addr = clr_we ? clr_addr : waddr_idx;
    mem_wr_data = clr_we ? '0 : wr_merged;
  end

  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem_q[mem_wr_addr] <= mem_wr_data;
    end
  end

  logic             src_valid, src_err;
  logic [WIDTH-1:0] src_data;

  if (RD_LATENCY == 2) begin : g_lat2
    logic             pipe_valid_q, pipe_err_q;
    logic [WIDTH-1:0] pipe_data_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe_valid_q <= 1'b0;
        pipe_err_q   <= 1'b0;
        pipe_data_q  <= '0;
      end else begin
        pipe_valid_q <= rd_now_valid;
        pipe_err_q   <= rd_now_err;
        pipe_data_q  <= rd_now_data;
      end
    end

    assign src_valid = pipe_valid_q;
    assign src_err   = pipe_err_q;
    assign src_data  = pipe_data_q;
  end else begin : g_lat1
    assign src_valid = rd_now_valid;
    assign src_err   = rd_now_err;
    assign src_data  = rd_now_data;
  end

  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d, err_q, err_d;

  always_comb begin
    rvalid_d = src_valid;
    rdata_d  = src_valid ? src_data : rdata_q;
    err_d    = wr_fault || (src_valid && src_err);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench: two RAM configurations share one stimulus stream, each row
// carries hand-computed outputs for both instances.
module tb_ram_sdp_be;

  // Instance A: DEPTH=8, RD_LATENCY=1, RDW_MODE=0.  Instance B: DEPTH=6, RD_LATENCY=2, RDW_MODE=1.
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0, re = 1'b0;
  logic [2:0]  waddr = '0, raddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbe = '0;

  logic [31:0] a_rdata, b_rdata;
  logic        a_rvalid, a_busy, a_err, b_rvalid, b_busy, b_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_sdp_be #(.WIDTH(32), .DEPTH(8), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(a_rdata), .rvalid(a_rvalid), .busy(a_busy), .err(a_err)
  );

  ram_sdp_be #(.WIDTH(32), .DEPTH(6), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(b_rdata), .rvalid(b_rvalid), .busy(b_busy), .err(b_err)
  );

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wbe;
    logic        re;
    logic [2:0]  ra;
    logic        av;
    logic [31:0] ad;
    logic        ae;
    logic        bv;
    logic [31:0] bd;
    logic        be;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic w, logic [2:0] wa, logic [31:0] wd, logic [3:0] bm,
                              logic r, logic [2:0] ra,
                              logic av, logic [31:0] ad, logic ae,
                              logic bv, logic [31:0] bd, logic be);
    vec_t v;
    v.we = w;  v.wa = wa; v.wd = wd; v.wbe = bm; v.re = r; v.ra = ra;
    v.av = av; v.ad = ad; v.ae = ae; v.bv = bv; v.bd = bd; v.be = be;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [2:0] wa, input logic [31:0] wd,
                       input logic [3:0] bm, input logic r, input logic [2:0] ra);
    we = w; waddr = wa; wdata = wd; wbe = bm; re = r; raddr = ra;
  endtask

  localparam logic [31:0] FULL = 32'hFFFF_FFFF;

  initial begin
    int a_cnt, b_cnt, hits;

    // Stimulus table
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 3'(i), 1, 0, 0, (i >= 1), 0, (i == 7)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    // byte-enable merge
    tbl.push_back(mk(1, 3, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 32'h00001200, 4'h2, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 1, 32'hDEAD12EF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hDEAD12EF, 0, 1, 32'hDEAD12EF, 0));
    // read-during-write, same and different address
    tbl.push_back(mk(1, 5, 32'h11111111, 4'hF, 0, 0, 0, 32'hDEAD12EF, 0, 0, 32'hDEAD12EF, 0));
    tbl.push_back(mk(1, 5, 32'hAAAAAAAA, 4'hF, 1, 5, 1, 32'h11111111, 0, 0, 32'hDEAD12EF, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5, 1, 32'hAAAAAAAA, 0, 1, 32'hAAAAAAAA, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hAAAAAAAA, 0, 1, 32'hAAAAAAAA, 0));
    tbl.push_back(mk(1, 5, 32'h000000CC, 4'h1, 1, 5, 1, 32'hAAAAAAAA, 0, 0, 32'hAAAAAAAA, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hAAAAAAAA, 0, 1, 32'hAAAAAACC, 0));
    tbl.push_back(mk(1, 4, 32'h44444444, 4'hF, 1, 5, 1, 32'hAAAAAACC, 0, 0, 32'hAAAAAACC, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hAAAAAACC, 0, 1, 32'hAAAAAACC, 0));
    // range faults (addr 6/7 are out of range only for B) and wbe=0 no-op
    tbl.push_back(mk(1, 1, 32'h12345678, 4'hF, 0, 0, 0, 32'hAAAAAACC, 0, 0, 32'hAAAAAACC, 0));
    tbl.push_back(mk(1, 7, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'hAAAAAACC, 0, 0, 32'hAAAAAACC, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 32'h12345678, 0, 0, 32'hAAAAAACC, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 6, 1, 0, 0, 1, 32'h12345678, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, FULL, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 32'h12345678, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 7, 1, 32'hDEADBEEF, 0, 1, 32'h12345678, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1, 0, 1));
    // back-to-back reads through the latency-2 pipeline
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 3'(k), 32'hA0 + 32'(k), 4'hF, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 3'(k), 1, 32'hA0 + 32'(k), 0,
                       (k > 0), (k > 0) ? 32'hA0 + 32'(k - 1) : 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hA3, 0, 1, 32'hA3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hA3, 0, 0, 32'hA3, 0));

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset a_busy", 32'(a_busy), 1);
    chk("reset b_busy", 32'(b_busy), 1);
    chk("reset a_rvalid", 32'(a_rvalid), 0);
    chk("reset b_err", 32'(b_err), 0);
    chk("reset a_rdata", a_rdata, 0);
    chk("reset b_rdata", b_rdata, 0);

    // Clear duration after release
    rst_n = 1'b1;
    a_cnt = 0;
    b_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (a_busy) a_cnt++;
      if (b_busy) b_cnt++;
      tick();
    end
    chk("clear cycles a", 32'(a_cnt), 8);
    chk("clear cycles b", 32'(b_cnt), 6);

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wbe, tbl[i].re, tbl[i].ra);
      tick();
      chk($sformatf("row%0d a_rvalid", i), 32'(a_rvalid), 32'(tbl[i].av));
      chk($sformatf("row%0d a_rdata", i), a_rdata, tbl[i].ad);
      chk($sformatf("row%0d a_err", i), 32'(a_err), 32'(tbl[i].ae));
      chk($sformatf("row%0d b_rvalid", i), 32'(b_rvalid), 32'(tbl[i].bv));
      chk($sformatf("row%0d b_rdata", i), b_rdata, tbl[i].bd);
      chk($sformatf("row%0d b_err", i), 32'(b_err), 32'(tbl[i].be));
    end

    // Reset with a read in flight in B's pipeline
    drive(0, 0, 0, 0, 1, 0);
    tick();
    chk("inflight a_rdata", a_rdata, 32'hA0);
    chk("inflight b_rvalid", 32'(b_rvalid), 0);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("midread b_rvalid", 32'(b_rvalid), 0);
    chk("midread b_rdata", b_rdata, 0);
    chk("midread a_busy", 32'(a_busy), 1);

    // Reset asserted in the 3rd clear cycle; writes attempted while busy
    rst_n = 1'b1;
    tick();
    chk("post reset b_rvalid", 32'(b_rvalid), 0);
    tick();
    rst_n = 1'b0;
    drive(1, 2, FULL, 4'hF, 0, 0);
    tick();
    chk("restart a_busy", 32'(a_busy), 1);
    rst_n = 1'b1;
    a_cnt = 0;
    hits = 0;
    for (int c = 0; c < 20; c++) begin
      if (a_busy) begin
        a_cnt++;
        if (a_rvalid || a_err) hits++;
        drive(1, 2, FULL, 4'hF, 1, 7);
      end else begin
        drive(0, 0, 0, 0, 0, 0);
      end
      tick();
    end
    chk("restart clear cycles a", 32'(a_cnt), 8);
    chk("busy ignores requests a", 32'(hits), 0);

    drive(0, 0, 0, 0, 1, 2);
    tick();
    chk("cleared addr2 a_rvalid", 32'(a_rvalid), 1);
    chk("cleared addr2 a_rdata", a_rdata, 0);
    drive(0, 0, 0, 0, 1, 1);
    tick();
    chk("cleared addr1 a_rdata", a_rdata, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("idle a_rvalid", 32'(a_rvalid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
